// File: rtl/ecpeta_error_monitor.sv
// Streaming error monitor for approximate adders: recomputes the exact sum,
// reports per-sample error distance and keeps saturating MED/ER statistics.
module ecpeta_error_monitor #(
  parameter int N     = 16,
  parameter int K     = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  input  logic             clear,
  output logic             res_valid,
  output logic [N-1:0]     res_ed,
  output logic             res_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     ed_max,
  output logic             frozen,
  output logic [7:0]       cfg_k
);

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  localparam int SUM_W = ((ACC_W > N) ? ACC_W : N) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PEN = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [SUM_W-1:0] ACC_SAT = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t state, state_nxt;

  logic         accept;
  logic         update;
  logic         s1_valid;
  logic [N-1:0] s1_sum;
  logic [N-1:0] s1_approx;
  logic [N-1:0] ed;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] ed_sum_nxt;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is combinational and never depends on in_valid. Results have no
  // backpressure: res_valid is a single-cycle pulse per surviving beat.
  assign in_ready = (state == RUN) && !clear;
  assign accept   = in_valid && in_ready;
  assign update   = s1_valid && !clear;
  assign frozen   = (state == FROZEN);
  assign cfg_k    = 8'(K);

  // S1: the exact sum wraps at N bits since the monitored adder has no carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_approx <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum    <= a + b;
        s1_approx <= approx_sum;
      end
    end
  end

  always_comb begin
    ed         = (s1_sum >= s1_approx) ? (s1_sum - s1_approx) : (s1_approx - s1_sum);
    sum_wide   = SUM_W'(ed_sum) + SUM_W'(ed);
    ed_sum_nxt = (sum_wide > ACC_SAT) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = RUN;
    end else if (state == RUN && update && sample_cnt == CNT_PEN) begin
      state_nxt = FROZEN;
    end
  end

  // S2: results and statistics land together, so stats match the res_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_ed     <= '0;
      res_err    <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (clear) begin
      res_valid  <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_ed  <= ed;
        res_err <= (ed != '0);
        if (sample_cnt != CNT_MAX) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
        end
        // Beats drained after freezing must not wrap the error count either.
        if (ed != '0 && err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        ed_sum <= ed_sum_nxt;
        if (ed > ed_max) begin
          ed_max <= ed;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecpeta_error_monitor.sv
// Self-checking bench for ecpeta_error_monitor: vector table plus scoreboard on
// a full-size instance, and a narrow-counter instance for saturation and freeze.
module tb_ecpeta_error_monitor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] approx_sum;
  logic        clear;
  logic        res_valid;
  logic [15:0] res_ed;
  logic        res_err;
  logic [31:0] sample_cnt;
  logic [31:0] err_cnt;
  logic [47:0] ed_sum;
  logic [15:0] ed_max;
  logic        frozen;
  logic [7:0]  cfg_k;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic [15:0] s_approx_sum;
  logic        s_clear;
  logic        s_res_valid;
  logic [15:0] s_res_ed;
  logic        s_res_err;
  logic [3:0]  s_sample_cnt;
  logic [3:0]  s_err_cnt;
  logic [5:0]  s_ed_sum;
  logic [15:0] s_ed_max;
  logic        s_frozen;
  logic [7:0]  s_cfg_k;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [31:0] m_cnt;
  logic [31:0] m_err;
  logic [47:0] m_sum;
  logic [15:0] m_max;
  logic [15:0] mon_e;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] approx;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[8];

  ecpeta_error_monitor #(.N(16), .K(8), .CNT_W(32), .ACC_W(48)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .clear(clear),
    .res_valid(res_valid), .res_ed(res_ed), .res_err(res_err),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum),
    .ed_max(ed_max), .frozen(frozen), .cfg_k(cfg_k)
  );

  ecpeta_error_monitor #(.N(16), .K(8), .CNT_W(4), .ACC_W(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .approx_sum(s_approx_sum), .clear(s_clear),
    .res_valid(s_res_valid), .res_ed(s_res_ed), .res_err(s_res_err),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .ed_sum(s_ed_sum),
    .ed_max(s_ed_max), .frozen(s_frozen), .cfg_k(s_cfg_k)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_ed(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] ap);
    logic [15:0] ex;
    ex = x + y;
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  task automatic model_zero();
    m_cnt = '0;
    m_err = '0;
    m_sum = '0;
    m_max = '0;
    exp_q.delete();
  endtask

  // driver: present a beat; queue its expectation only if it will be accepted
  task automatic drive(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ap, input logic [15:0] e);
    @(negedge clk);
    a = x;
    b = y;
    approx_sum = ap;
    in_valid = 1'b1;
    #1;
    if (in_ready) exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: pop expected distance per result pulse and track statistics
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_res_valid: got res_ed 0x%0h required no result", res_ed);
      end else begin
        mon_e = exp_q.pop_front();
        m_cnt = m_cnt + 32'd1;
        if (mon_e != 16'd0) m_err = m_err + 32'd1;
        m_sum = m_sum + 48'(mon_e);
        if (mon_e > m_max) m_max = mon_e;
        check("res_ed", 64'(res_ed), 64'(mon_e));
        check("res_err", 64'(res_err), 64'(mon_e != 16'd0));
        check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        check("err_cnt", 64'(err_cnt), 64'(m_err));
        check("ed_sum", 64'(ed_sum), 64'(m_sum));
        check("ed_max", 64'(ed_max), 64'(m_max));
      end
    end
  end

  initial begin
    int pulses;
    bit seen15;
    logic [15:0] ra, rb, rap;

    vecs[0] = '{16'h00FF, 16'h0001, 16'h00FF, 16'h0001};
    vecs[1] = '{16'h0010, 16'h0010, 16'h0030, 16'h0010};
    vecs[2] = '{16'hFFFF, 16'h0002, 16'h0001, 16'h0000};
    vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h1000, 16'h0100, 16'h1000, 16'h0100};
    vecs[6] = '{16'h7FFF, 16'h0001, 16'h7FF0, 16'h0010};
    vecs[7] = '{16'hABCD, 16'h1111, 16'hBCDE, 16'h0000};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; approx_sum = '0; clear = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_approx_sum = '0; s_clear = 1'b0;
    model_zero();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_ed", 64'(res_ed), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_ed_sum", 64'(ed_sum), 64'd0);
    check("rst_ed_max", 64'(ed_max), 64'd0);
    check("rst_frozen", 64'(frozen), 64'd0);
    check("cfg_k", 64'(cfg_k), 64'd8);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // exact match and two-edge latency
    drive(16'h1234, 16'h0101, 16'h1335, 16'h0000);
    @(posedge clk);
    #1;
    check("latency_edge1_no_result", 64'(res_valid), 64'd0);
    idle();
    @(posedge clk);
    #1;
    check("latency_edge2_result", 64'(res_valid), 64'd1);
    drain();

    // vector table, back to back
    for (int i = 0; i < 8; i++) drive(vecs[i].a, vecs[i].b, vecs[i].approx, vecs[i].ed);
    idle();
    drain();
    check("table_err_cnt", 64'(err_cnt), 64'd5);
    check("table_ed_max", 64'(ed_max), 64'hFFFF);

    // clear, then 100 random beats back to back
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    model_zero();
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rap = (ra + rb) ^ 16'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 511));
      drive(ra, rb, rap, ref_ed(ra, rb, rap));
      check("b2b_in_ready", 64'(in_ready), 64'd1);
    end
    idle();
    drain();
    check("b2b_sample_cnt", 64'(sample_cnt), 64'd100);

    // clear with beats in flight and in_valid high
    drive(16'h0003, 16'h0004, 16'h0009, 16'h0002);
    drive(16'h0100, 16'h0001, 16'h0000, 16'h0101);
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; approx_sum = 16'h0000;
    in_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("clear_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    model_zero();
    check("clear_res_valid", 64'(res_valid), 64'd0);
    check("clear_sample_cnt", 64'(sample_cnt), 64'd0);
    check("clear_err_cnt", 64'(err_cnt), 64'd0);
    check("clear_ed_sum", 64'(ed_sum), 64'd0);
    check("clear_ed_max", 64'(ed_max), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("after_clear_sample_cnt", 64'(sample_cnt), 64'd0);

    // asynchronous reset mid-stream
    drive(16'h0001, 16'h0001, 16'h0000, 16'h0002);
    drive(16'h0002, 16'h0002, 16'h0000, 16'h0004);
    drive(16'h0003, 16'h0003, 16'h0000, 16'h0006);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", 64'(res_valid), 64'd0);
    check("arst_res_ed", 64'(res_ed), 64'd0);
    check("arst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    check("arst_ed_sum", 64'(ed_sum), 64'd0);
    check("arst_ed_max", 64'(ed_max), 64'd0);
    in_valid = 1'b0;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drive(16'h0020, 16'h0020, 16'h0041, 16'h0001);
    idle();
    drain();

    // saturation and freeze on the narrow instance: every sample has ed 0x10
    @(negedge clk);
    s_a = 16'h0010; s_b = 16'h0000; s_approx_sum = 16'h0000;
    s_in_valid = 1'b1;
    pulses = 0;
    seen15 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_res_valid) begin
        pulses++;
        if (pulses == 3) check("sat_ed_sum_48", 64'(s_ed_sum), 64'd48);
        if (pulses == 4) check("sat_ed_sum_63", 64'(s_ed_sum), 64'd63);
      end
      if (s_sample_cnt == 4'd15 && !seen15) begin
        seen15 = 1'b1;
        check("freeze_frozen", 64'(s_frozen), 64'd1);
        check("freeze_in_ready", 64'(s_in_ready), 64'd0);
      end
    end
    check("freeze_reached", 64'(seen15), 64'd1);
    check("sat_pulses", 64'(pulses), 64'd16);
    check("sat_held_frozen", 64'(s_frozen), 64'd1);
    check("sat_held_in_ready", 64'(s_in_ready), 64'd0);
    check("sat_sample_cnt", 64'(s_sample_cnt), 64'd15);
    check("sat_ed_sum_final", 64'(s_ed_sum), 64'd63);
    check("sat_ed_max", 64'(s_ed_max), 64'h10);
    @(negedge clk);
    s_clear = 1'b1;
    s_in_valid = 1'b0;
    @(negedge clk);
    s_clear = 1'b0;
    #1;
    check("sat_clear_frozen", 64'(s_frozen), 64'd0);
    check("sat_clear_sample_cnt", 64'(s_sample_cnt), 64'd0);
    check("sat_clear_ed_sum", 64'(s_ed_sum), 64'd0);
    check("sat_clear_in_ready", 64'(s_in_ready), 64'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecpeta_error_monitor.md
# ecpeta_error_monitor

Streaming error-characterisation monitor for the approximate adders. Accepts operand pairs together with the approximate adder's sum, recomputes the exact sum internally and reports per-sample error distance. Keeps running statistics (sample count, erroneous-sample count, error-distance sum and maximum) so a bench or on-chip harness can measure the mean error distance (MED) and error rate (ER) of an approximate adder instance.

## Interface

- N, 16, operand and sum width; must match the monitored adder.
- K, 8, accurate-part width of the monitored adder; informational only, exported on `cfg_k`.
- CNT_W, 32, width of `sample_cnt` and `err_cnt`.
- ACC_W, 48, width of `ed_sum`.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample presented.
- in_ready  out  1  monitor can accept the sample this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- approx_sum  in  N  approximate adder output for (a, b).
- clear  in  1  synchronous statistics clear and pipeline flush.
- res_valid  out  1  one-cycle pulse; per-sample result valid.
- res_ed  out  N  per-sample error distance.
- res_err  out  1  per-sample flag: `res_ed` != 0.
- sample_cnt  out  CNT_W  accepted samples since reset or clear.
- err_cnt  out  CNT_W  samples with nonzero error distance.
- ed_sum  out  ACC_W  saturating sum of error distances.
- ed_max  out  N  largest error distance seen.
- frozen  out  1  statistics saturated; input stalled.
- cfg_k  out  8  constant K.

## Operation

- Accept: a beat is accepted when `in_valid && in_ready`.
- `in_ready` = (state == RUN) && !clear (combinational).
- Exact reference: `exact` = (a + b) mod 2^N. The carry-out is discarded because the approximate adder exposes no carry-out.
- Error distance: `ed` = |exact - approx_sum|, computed as an unsigned N-bit magnitude (larger minus smaller).
- Stage S1: register a + b (N bits), `approx_sum`, and a valid bit.
- Stage S2: compute `ed`, drive `res_*`, and update the statistics.
- Statistics update per S2-valid sample:
  - `sample_cnt` += 1.
  - `err_cnt` += (ed != 0).
  - `ed_sum` += ed; saturates at 2^ACC_W-1 and stays there.
  - `ed_max` = max(`ed_max`, ed).
- FSM has two states, RUN and FROZEN.
  - RUN → FROZEN when a S2 update makes `sample_cnt` reach 2^CNT_W-1. Beats already in S1 still complete and update the statistics, except `sample_cnt`, which holds at its maximum.
  - FROZEN → RUN only on `clear`.
  - `frozen` = (state == FROZEN).
- Clear:
  - Next edge: all statistics go to 0, both pipeline valid bits go to 0, state goes to RUN.
  - In-flight beats are discarded: no `res_valid` and no statistics update for them.
  - `clear` together with `in_valid`: `clear` wins and the beat is not accepted.
- Reset values: `res_valid` 0, `res_ed` 0, `res_err` 0, `sample_cnt` 0, `err_cnt` 0, `ed_sum` 0, `ed_max` 0, `frozen` 0, state RUN, pipeline valids 0. `in_ready` is 1 once `rst_n` is high.
- Reset mid-operation: asynchronous, takes effect immediately, and discards in-flight beats.

## Timing

- Latency: a beat accepted at edge T produces `res_valid` = 1 in the cycle after edge T+1, i.e. results are registered 2 edges after acceptance.
- Statistics outputs reflect the sample in the same cycle `res_valid` is high.
- Throughput: 1 sample per cycle in RUN. There is no backpressure on the result side.
- `res_ed` and `res_err` hold their last value when `res_valid` = 0.
- `in_ready` drops in the same cycle `clear` is asserted and in every cycle in FROZEN.

## Test plan

- Reset then exact match: a=0x1234, b=0x0101, approx_sum=0x1335. Required: `res_valid` 2 edges later, `res_ed`=0, `res_err`=0, `sample_cnt`=1, `err_cnt`=0.
- Error both directions:
  - a=0x00FF, b=0x0001, approx_sum=0x00FF → `res_ed`=1.
  - Next beat a=0x0010, b=0x0010, approx_sum=0x0030 → `res_ed`=0x10.
  - Required after both: `err_cnt`=2, `ed_sum`=0x11, `ed_max`=0x10.
- Overflow wrap: a=0xFFFF, b=0x0002, approx_sum=0x0001. Required: exact=0x0001 and `res_ed`=0.
- Back-to-back: 100 consecutive beats with `in_valid` held high. Required: `in_ready` stays 1, 100 `res_valid` pulses arrive in order, `sample_cnt`=100.
- Clear:
  - Assert `clear` with 2 beats in flight and `in_valid`=1. Required: `in_ready`=0 that cycle, no `res_valid` for the flushed beats, all statistics read 0 on the next cycle.
  - Reassert `rst_n` low mid-stream. Required: all outputs at reset values asynchronously.
- Saturation (CNT_W=4, ACC_W=6): feed samples with ed=0x10.
  - Required: `ed_sum` sticks at 63.
  - Required: `frozen`=1 and `in_ready`=0 once `sample_cnt`=15, held until `clear`, after which state returns to RUN.
